bsg_link_traffic_node: RTL and testbench

Parametrised loopback traffic generator and checker for bringup of bsg_link channels in the gateway and ASIC test benches. It supersedes the fixed-pattern hardened test node with several additions: a selectable data pattern, a programmable packet limit, a bound on outstanding flits, a drain phase with timeout, and capture of the first error. One instance drives one ready/valid link (with its return path looped back through the link under test) and checks that every returned flit matches the sent sequence in order.

---
 rtl/bsg_link_traffic_node.sv | 226 ++++++++++++++++++++++
 tb/tb_bsg_link_traffic_node.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_link_traffic_node.sv
// bsg_link_traffic_node: loopback traffic generator and in-order checker for
// one bsg_link ready/valid channel. Sends a selectable pattern (counter, LFSR,
// walking-one), checks every returned flit against an independent reference
// generator, bounds outstanding flits, drains with a timeout and captures the
// first error.
module bsg_link_traffic_node #(
    parameter int          channel_width_p = 8,
    parameter int          num_channels_p  = 2,
    parameter int          els_p           = 16,
    parameter logic [31:0] lfsr_seed_p     = 32'hACE1_0001,
    parameter int          drain_timeout_p = 1024,
    localparam int         width_lp        = channel_width_p * num_channels_p
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                en_i,
    input  logic [1:0]          mode_i,
    input  logic [31:0]         limit_i,
    output logic                v_o,
    output logic [width_lp-1:0] data_o,
    input  logic                ready_i,
    input  logic                v_i,
    input  logic [width_lp-1:0] data_i,
    output logic                ready_o,
    output logic [31:0]         sent_o,
    output logic [31:0]         received_o,
    output logic                error_o,
    output logic [31:0]         err_idx_o,
    output logic [width_lp-1:0] err_data_o,
    output logic                done_o,
    output logic                timeout_o
);

    localparam int outst_w_lp = $clog2(els_p + 1);
    localparam int walk_w_lp  = (width_lp > 1) ? $clog2(width_lp) : 1;
    localparam int drain_w_lp = (drain_timeout_p > 1) ? $clog2(drain_timeout_p + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Galois LFSR, x^32+x^22+x^2+x+1, right-shifting form.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Counter that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [walk_w_lp-1:0] walk_inc(input logic [walk_w_lp-1:0] w);
        return (w == walk_w_lp'(width_lp - 1)) ? '0 : w + walk_w_lp'(1);
    endfunction

    // Builds the flit for one generator state under the given pattern mode.
    function automatic logic [width_lp-1:0] make_flit(
        input logic [1:0]                 mode,
        input logic [channel_width_p-1:0] cnt,
        input logic [31:0]                lfsr,
        input logic [walk_w_lp-1:0]       walk
    );
        logic [width_lp-1:0] f;
        f = '0;
        if (mode == 2'd2) begin
            f = width_lp'(1) << walk;
        end else begin
            for (int c = 0; c < num_channels_p; c++) begin
                if (mode == 2'd1)
                    f[c*channel_width_p +: channel_width_p] =
                        channel_width_p'(lfsr) ^ channel_width_p'(c);
                else
                    f[c*channel_width_p +: channel_width_p] = cnt + channel_width_p'(c);
            end
        end
        return f;
    endfunction

    state_e                     state_q;
    logic [1:0]                 mode_q;
    logic [31:0]                limit_q;
    logic                       done_q, timeout_q, alive_q;
    logic [drain_w_lp-1:0]      drain_cnt_q;

    logic [channel_width_p-1:0] tx_cnt_q, rx_cnt_q;
    logic [31:0]                tx_lfsr_q, rx_lfsr_q;
    logic [walk_w_lp-1:0]       tx_walk_q, rx_walk_q;
    logic [width_lp-1:0]        data_q;
    logic [31:0]                sent_q, recv_q;
    logic [outst_w_lp-1:0]      outst_q;
    logic                       error_q;
    logic [31:0]                err_idx_q;
    logic [width_lp-1:0]        err_data_q;

    logic                       start, tx_hs, rx_hs, rx_exp, rx_err, limit_hit;
    logic [1:0]                 start_mode;
    logic [width_lp-1:0]        rx_ref;
    logic [31:0]                sent_d, recv_d;
    logic [outst_w_lp-1:0]      outst_d;

    // Handshakes, checker compare and next-state counts.
    always_comb begin
        start      = (state_q == IDLE) && en_i;
        start_mode = (mode_i == 2'd3) ? 2'd0 : mode_i;
        v_o        = (state_q == RUN) && (outst_q < outst_w_lp'(els_p)) &&
                     ((limit_q == 32'd0) || (sent_q < limit_q));
        ready_o    = alive_q;
        tx_hs      = v_o && ready_i;
        rx_hs      = v_i && ready_o;
        rx_exp     = rx_hs && (outst_q != '0);
        rx_ref     = make_flit(mode_q, rx_cnt_q, rx_lfsr_q, rx_walk_q);
        rx_err     = rx_hs && ((outst_q == '0) || (data_i != rx_ref));
        sent_d     = tx_hs ? sat_inc(sent_q) : sent_q;
        recv_d     = rx_hs ? sat_inc(recv_q) : recv_q;
        limit_hit  = (limit_q != 32'd0) && (sent_d >= limit_q);
        outst_d    = outst_q;
        if (tx_hs && !rx_exp)      outst_d = outst_q + outst_w_lp'(1);
        else if (!tx_hs && rx_exp) outst_d = outst_q - outst_w_lp'(1);
    end

    // Control FSM with registered done/timeout outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            mode_q      <= 2'd0;
            limit_q     <= 32'd0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            drain_cnt_q <= '0;
            alive_q     <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            case (state_q)
                IDLE: if (en_i) begin
                    state_q   <= RUN;
                    mode_q    <= start_mode;
                    limit_q   <= limit_i;
                    timeout_q <= 1'b0;
                end
                RUN: if (!en_i || limit_hit) begin
                    state_q     <= DRAIN;
                    drain_cnt_q <= '0;
                end
                DRAIN: begin
                    if (outst_q == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (drain_cnt_q == drain_w_lp'(drain_timeout_p - 1)) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + drain_w_lp'(1);
                    end
                end
                DONE: if (!en_i) begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Generators, counters and first-error capture.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            tx_cnt_q   <= '0;
            tx_lfsr_q  <= '0;
            tx_walk_q  <= '0;
            rx_cnt_q   <= '0;
            rx_lfsr_q  <= '0;
            rx_walk_q  <= '0;
            data_q     <= '0;
            sent_q     <= 32'd0;
            recv_q     <= 32'd0;
            outst_q    <= '0;
            error_q    <= 1'b0;
            err_idx_q  <= 32'd0;
            err_data_q <= '0;
        end else if (start) begin
            tx_cnt_q   <= '0;
            tx_lfsr_q  <= lfsr_seed_p;
            tx_walk_q  <= '0;
            rx_cnt_q   <= '0;
            rx_lfsr_q  <= lfsr_seed_p;
            rx_walk_q  <= '0;
            data_q     <= make_flit(start_mode, '0, lfsr_seed_p, '0);
            sent_q     <= 32'd0;
            recv_q     <= 32'd0;
            outst_q    <= '0;
            error_q    <= 1'b0;
            err_idx_q  <= 32'd0;
            err_data_q <= '0;
        end else begin
            sent_q  <= sent_d;
            recv_q  <= recv_d;
            outst_q <= outst_d;
            if (tx_hs) begin
                tx_cnt_q  <= tx_cnt_q + channel_width_p'(1);
                tx_lfsr_q <= lfsr_next(tx_lfsr_q);
                tx_walk_q <= walk_inc(tx_walk_q);
                data_q    <= make_flit(mode_q, tx_cnt_q + channel_width_p'(1),
                                       lfsr_next(tx_lfsr_q), walk_inc(tx_walk_q));
            end
            if (rx_exp) begin
                rx_cnt_q  <= rx_cnt_q + channel_width_p'(1);
                rx_lfsr_q <= lfsr_next(rx_lfsr_q);
                rx_walk_q <= walk_inc(rx_walk_q);
            end
            if (rx_err && !error_q) begin
                error_q    <= 1'b1;
                err_idx_q  <= recv_q;
                err_data_q <= data_i;
            end
        end
    end

    assign data_o     = data_q;
    assign sent_o     = sent_q;
    assign received_o = recv_q;
    assign error_o    = error_q;
    assign err_idx_o  = err_idx_q;
    assign err_data_o = err_data_q;
    assign done_o     = done_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_bsg_link_traffic_node.sv
// Directed bench for bsg_link_traffic_node with a modelled loopback link.
module tb_bsg_link_traffic_node;

    logic        clk = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        en_i = 1'b0;
    logic [1:0]  mode_i = 2'd0;
    logic [31:0] limit_i = 32'd0;
    logic        v_o;
    logic [15:0] data_o;
    logic        ready_i = 1'b1;
    logic        v_i = 1'b0;
    logic [15:0] data_i = 16'h0;
    logic        ready_o;
    logic [31:0] sent_o, received_o, err_idx_o;
    logic        error_o, done_o, timeout_o;
    logic [15:0] err_data_o;

    int checks = 0;
    int errors = 0;

    // loopback link and reference model state
    logic [15:0] lb_q[$];
    int          lb_t[$];
    int          cyc = 0;
    int          lb_delay = 0;
    bit          loop_en = 1'b1;
    bit          stall_en = 1'b0;
    int          cor_a = -1, cor_b = -1;
    int          tx_n = 0, tx_bad = 0, hold_bad = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [31:0] m_lfsr = 32'hACE1_0001;
    logic [15:0] tx_log[2048];

    bsg_link_traffic_node #(
        .channel_width_p(8), .num_channels_p(2), .els_p(16),
        .lfsr_seed_p(32'hACE1_0001), .drain_timeout_p(64)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .en_i(en_i), .mode_i(mode_i),
        .limit_i(limit_i), .v_o(v_o), .data_o(data_o), .ready_i(ready_i),
        .v_i(v_i), .data_i(data_i), .ready_o(ready_o), .sent_o(sent_o),
        .received_o(received_o), .error_o(error_o), .err_idx_o(err_idx_o),
        .err_data_o(err_data_o), .done_o(done_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_flit();
        logic [15:0] f;
        logic [15:0] one;
        one = 16'h0001;
        f = 16'h0;
        case (m_mode)
            2'd1: begin
                f[7:0]  = m_lfsr[7:0];
                f[15:8] = m_lfsr[7:0] ^ 8'h01;
            end
            2'd2: f = one << (tx_n % 16);
            default: begin
                f[7:0]  = 8'(tx_n);
                f[15:8] = 8'(tx_n + 1);
            end
        endcase
        return f;
    endfunction

    // One clock: record handshakes, model the link, drive next inputs.
    task automatic cycle();
        logic txh, rxh, stall;
        logic [15:0] txd, dummy;
        int dummy_t;
        txh = v_o && ready_i;
        rxh = v_i && ready_o;
        stall = v_o && !ready_i;
        txd = data_o;
        @(posedge clk);
        #1;
        cyc++;
        if (stall && (v_o !== 1'b1 || data_o !== txd)) hold_bad++;
        if (rxh && lb_q.size() > 0) begin
            dummy = lb_q.pop_front();
            dummy_t = lb_t.pop_front();
        end
        if (txh) begin
            if (txd !== model_flit()) tx_bad++;
            if (tx_n < 2048) tx_log[tx_n] = txd;
            if (loop_en) begin
                lb_q.push_back((tx_n == cor_a || tx_n == cor_b) ? (txd ^ 16'h0008) : txd);
                lb_t.push_back(cyc);
            end
            tx_n++;
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
        end
        ready_i = !(stall_en && ($urandom_range(0, 99) < 30));
        if (lb_q.size() > 0 && (cyc - lb_t[0]) >= lb_delay &&
            !(stall_en && ($urandom_range(0, 99) < 30))) begin
            v_i = 1'b1;
            data_i = lb_q[0];
        end else begin
            v_i = 1'b0;
            data_i = 16'h0;
        end
    endtask

    task automatic start_run(input logic [1:0] mode, input logic [31:0] lim);
        tx_n = 0;
        tx_bad = 0;
        hold_bad = 0;
        m_mode = (mode == 2'd3) ? 2'd0 : mode;
        m_lfsr = 32'hACE1_0001;
        lb_q.delete();
        lb_t.delete();
        mode_i = mode;
        limit_i = lim;
        en_i = 1'b1;
        cycle();
    endtask

    task automatic run_until_done(input int budget, output int n);
        n = 0;
        while (!done_o && n < budget) begin
            cycle();
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        cycle();
        cycle();
        checks++; if (v_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL reset_hs: v_o=%b ready_o=%b required 0 0", v_o, ready_o); end
        checks++; if (data_o !== 16'h0 || sent_o !== 0 || received_o !== 0) begin errors++; $display("FAIL reset_data: data=%h sent=%0d recv=%0d required 0", data_o, sent_o, received_o); end
        checks++; if (error_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL reset_flags: err=%b done=%b to=%b required 0", error_o, done_o, timeout_o); end
        reset_n_i = 1'b1;
        cycle();
        checks++; if (ready_o !== 1'b1 || v_o !== 1'b0) begin errors++; $display("FAIL reset_release: ready_o=%b v_o=%b required 1 0", ready_o, v_o); end
    endtask

    task automatic test_counter();
        int n;
        lb_delay = 0; stall_en = 1'b0;
        start_run(2'd0, 32'd100);
        checks++; if (v_o !== 1'b1 || data_o !== 16'h0100) begin errors++; $display("FAIL ctr_first: v_o=%b data=%h required 1 0100", v_o, data_o); end
        run_until_done(1000, n);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL ctr_done: done=%b required 1", done_o); end
        checks++; if (sent_o !== 100 || received_o !== 100) begin errors++; $display("FAIL ctr_counts: sent=%0d recv=%0d required 100 100", sent_o, received_o); end
        checks++; if (error_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL ctr_flags: err=%b to=%b required 0 0", error_o, timeout_o); end
        checks++; if (tx_log[5] !== 16'h0605) begin errors++; $display("FAIL ctr_flit5: got %h required 0605", tx_log[5]); end
        checks++; if (tx_bad !== 0) begin errors++; $display("FAIL ctr_stream: %0d bad flits required 0", tx_bad); end
        en_i = 1'b0;
        cycle();
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL ctr_idle: done=%b required 0", done_o); end
    endtask

    task automatic test_lfsr();
        int n;
        lb_delay = 4; stall_en = 1'b1;
        start_run(2'd1, 32'd1000);
        checks++; if (v_o !== 1'b1 || data_o !== 16'h0001) begin errors++; $display("FAIL lfsr_first: v_o=%b data=%h required 1 0001", v_o, data_o); end
        run_until_done(20000, n);
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL lfsr_done: done=%b required 1", done_o); end
        checks++; if (sent_o !== 1000 || received_o !== 1000) begin errors++; $display("FAIL lfsr_counts: sent=%0d recv=%0d required 1000 1000", sent_o, received_o); end
        checks++; if (error_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL lfsr_flags: err=%b to=%b required 0 0", error_o, timeout_o); end
        checks++; if (tx_log[1] !== 16'h0203) begin errors++; $display("FAIL lfsr_flit1: got %h required 0203", tx_log[1]); end
        checks++; if (tx_bad !== 0) begin errors++; $display("FAIL lfsr_stream: %0d bad flits required 0", tx_bad); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL lfsr_hold: %0d unstable stalls required 0", hold_bad); end
        stall_en = 1'b0;
        en_i = 1'b0;
        cycle();
    endtask

    task automatic test_walk_error();
        int n;
        lb_delay = 0; stall_en = 1'b0;
        cor_a = 7; cor_b = 9;
        start_run(2'd2, 32'd20);
        checks++; if (data_o !== 16'h0001) begin errors++; $display("FAIL walk_first: data=%h required 0001", data_o); end
        run_until_done(500, n);
        checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL walk_err: err=%b required 1", error_o); end
        checks++; if (err_idx_o !== 7 || err_data_o !== 16'h0088) begin errors++; $display("FAIL walk_capture: idx=%0d data=%h required 7 0088", err_idx_o, err_data_o); end
        checks++; if (sent_o !== 20 || received_o !== 20 || done_o !== 1'b1) begin errors++; $display("FAIL walk_counts: sent=%0d recv=%0d done=%b required 20 20 1", sent_o, received_o, done_o); end
        checks++; if (tx_bad !== 0) begin errors++; $display("FAIL walk_stream: %0d bad flits required 0", tx_bad); end
        cor_a = -1; cor_b = -1;
        en_i = 1'b0;
        cycle();
    endtask

    task automatic test_disconnect();
        int n;
        loop_en = 1'b0;
        start_run(2'd0, 32'd0);
        for (int i = 0; i < 40; i++) cycle();
        checks++; if (sent_o !== 16 || v_o !== 1'b0) begin errors++; $display("FAIL disc_bound: sent=%0d v_o=%b required 16 0", sent_o, v_o); end
        en_i = 1'b0;
        run_until_done(500, n);
        checks++; if (n !== 65 || done_o !== 1'b1) begin errors++; $display("FAIL disc_drain: cycles=%0d done=%b required 65 1", n, done_o); end
        checks++; if (timeout_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL disc_timeout: to=%b err=%b required 1 0", timeout_o, error_o); end
        cycle();
        checks++; if (done_o !== 1'b0 || timeout_o !== 1'b1) begin errors++; $display("FAIL disc_sticky: done=%b to=%b required 0 1", done_o, timeout_o); end
        loop_en = 1'b1;
    endtask

    task automatic test_unlimited_stop();
        int n;
        lb_delay = 2; stall_en = 1'b0;
        start_run(2'd3, 32'd0);
        for (int i = 1; i < 500; i++) cycle();
        en_i = 1'b0;
        run_until_done(200, n);
        checks++; if (done_o !== 1'b1 || timeout_o !== 1'b0) begin errors++; $display("FAIL unl_done: done=%b to=%b required 1 0", done_o, timeout_o); end
        checks++; if (sent_o !== 500 || received_o !== 500) begin errors++; $display("FAIL unl_counts: sent=%0d recv=%0d required 500 500", sent_o, received_o); end
        checks++; if (error_o !== 1'b0 || tx_bad !== 0) begin errors++; $display("FAIL unl_check: err=%b bad=%0d required 0 0", error_o, tx_bad); end
        cycle();
        start_run(2'd0, 32'd0);
        checks++; if (sent_o !== 0 || received_o !== 0) begin errors++; $display("FAIL unl_restart_clr: sent=%0d recv=%0d required 0 0", sent_o, received_o); end
        checks++; if (v_o !== 1'b1 || data_o !== 16'h0100) begin errors++; $display("FAIL unl_restart_flit: v_o=%b data=%h required 1 0100", v_o, data_o); end
        en_i = 1'b0;
        run_until_done(200, n);
        checks++; if (sent_o !== 1 || received_o !== 1 || done_o !== 1'b1) begin errors++; $display("FAIL unl_restart_drain: sent=%0d recv=%0d done=%b required 1 1 1", sent_o, received_o, done_o); end
        cycle();
    endtask

    task automatic test_reset_midrun();
        lb_delay = 0; stall_en = 1'b0;
        start_run(2'd0, 32'd0);
        for (int i = 0; i < 20; i++) cycle();
        reset_n_i = 1'b0;
        cycle();
        checks++; if (v_o !== 1'b0 || ready_o !== 1'b0 || data_o !== 16'h0) begin errors++; $display("FAIL rst_mid_hs: v_o=%b ready_o=%b data=%h required 0 0 0000", v_o, ready_o, data_o); end
        checks++; if (sent_o !== 0 || received_o !== 0 || err_idx_o !== 0 || err_data_o !== 16'h0) begin errors++; $display("FAIL rst_mid_cnt: sent=%0d recv=%0d idx=%0d ed=%h required 0", sent_o, received_o, err_idx_o, err_data_o); end
        checks++; if (error_o !== 1'b0 || done_o !== 1'b0 || timeout_o !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: err=%b done=%b to=%b required 0", error_o, done_o, timeout_o); end
        reset_n_i = 1'b1;
        en_i = 1'b0;
        lb_q.delete();
        lb_t.delete();
        v_i = 1'b0;
        cycle();
        checks++; if (ready_o !== 1'b1 || error_o !== 1'b0) begin errors++; $display("FAIL rst_idle: ready_o=%b err=%b required 1 0", ready_o, error_o); end
        lb_q.push_back(16'h1234);
        lb_t.push_back(cyc - 100);
        v_i = 1'b1;
        data_i = 16'h1234;
        cycle();
        checks++; if (error_o !== 1'b1 || err_idx_o !== 0 || err_data_o !== 16'h1234) begin errors++; $display("FAIL stray_rx: err=%b idx=%0d data=%h required 1 0 1234", error_o, err_idx_o, err_data_o); end
        checks++; if (received_o !== 1) begin errors++; $display("FAIL stray_count: recv=%0d required 1", received_o); end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_lfsr();
        test_walk_error();
        test_disconnect();
        test_unlimited_stop();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
